// File: rtl/lsu_ram_pkg.sv
// lsu_ram shared types and helpers.
// Access-size decode, split detection and byte-lane masks.
package lsu_ram_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    typedef enum logic {
        ST_IDLE,
        ST_SPLIT
    } state_e;

    // Unsigned sizes are only meaningful when something is read back.
    function automatic logic is_legal(logic [2:0] f3, logic ld);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ld;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_split(logic [2:0] f3, logic [1:0] off);
        logic sp;
        sp = 1'b0;
        case (f3)
            F3_W:         sp = (off != 2'd0);
            F3_H, F3_HU:  sp = (off == 2'd3);
            default:      sp = 1'b0;
        endcase
        return sp;
    endfunction

    // Low nibble is the first word, high nibble the following word.
    function automatic logic [7:0] byte_en(logic [2:0] f3, logic [1:0] off);
        logic [7:0] m;
        m = 8'h00;
        case (f3)
            F3_B, F3_BU: m = 8'h01;
            F3_H, F3_HU: m = 8'h03;
            F3_W:        m = 8'h0F;
            default:     m = 8'h00;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/lsu_ram_bram_be.sv
// Single-port word RAM with per-byte write enables.
// Read returns the contents before any same-cycle write.
module bram_be #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    // Synchronous read of old data plus byte-masked write.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_addr];
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_ram.sv
// Byte-addressable RV32 data memory with split misaligned access.
// One response per accepted request; loads sign/zero-extended.
module lsu_ram
    import lsu_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  store,
    input  logic                  load,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  resp_valid,
    output logic                  resp_split,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int WAW = ADDR_WIDTH - 2;

    if (DATA_WIDTH != 32) begin : g_dw_chk
        $error("lsu_ram: DATA_WIDTH must be 32");
    end

    state_e         r_state;
    logic           r_rdy;
    logic [2:0]     r_f3;
    logic [1:0]     r_off;
    logic           r_split;
    logic           r_st;
    logic           r_ld;
    logic [3:0]     r_be_hi;
    logic [31:0]    r_wd_hi;
    logic [WAW-1:0] r_wa_nx;
    logic           r_rsp_valid;
    logic           r_rsp_split;
    logic           r_rsp_err;
    logic           r_rsp_ld;
    logic [31:0]    r_lo;
    logic [31:0]    r_hold;

    logic           w_acc;
    logic           w_legal;
    logic           w_split;
    logic [1:0]     w_off;
    logic [WAW-1:0] w_wa;
    logic [7:0]     w_be;
    logic [63:0]    w_wd;
    logic [WAW-1:0] w_mem_addr;
    logic [3:0]     w_mem_we;
    logic [31:0]    w_mem_wd;
    logic [31:0]    w_rdata;
    logic [63:0]    w_raw;
    logic [31:0]    w_sh;
    logic [31:0]    w_ld_val;

    assign req_ready = (r_state == ST_IDLE) && r_rdy;
    assign w_acc     = req_valid && req_ready && (store || load);
    assign w_off     = address[1:0];
    assign w_wa      = address[ADDR_WIDTH-1:2];
    assign w_legal   = is_legal(funct3, load);
    assign w_split   = w_legal && is_split(funct3, w_off);
    assign w_be      = w_legal ? byte_en(funct3, w_off) : 8'h00;
    assign w_wd      = {32'h0, data_in} << {w_off, 3'b000};

    // RAM port: beat 0 straight from the request, beat 1 from capture.
    always_comb begin
        w_mem_addr = w_wa;
        w_mem_we   = 4'h0;
        w_mem_wd   = w_wd[31:0];
        if (r_state == ST_SPLIT) begin
            w_mem_addr = r_wa_nx;
            w_mem_we   = r_st ? r_be_hi : 4'h0;
            w_mem_wd   = r_wd_hi;
        end else if (w_acc && store) begin
            w_mem_we   = w_be[3:0];
        end
    end

    bram_be #(
        .AW(WAW)
    ) u_bram (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .i_we    (w_mem_we),
        .i_wdata (w_mem_wd),
        .o_rdata (w_rdata)
    );

    // FSM, request capture and registered response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rdy       <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_split     <= 1'b0;
            r_st        <= 1'b0;
            r_ld        <= 1'b0;
            r_be_hi     <= 4'h0;
            r_wd_hi     <= 32'h0;
            r_wa_nx     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_split <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ld    <= 1'b0;
            r_lo        <= 32'h0;
            r_hold      <= 32'h0;
        end else begin
            r_rdy       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_split <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ld    <= 1'b0;
            if (r_rsp_ld) begin
                r_hold <= w_ld_val;
            end else if (r_rsp_err) begin
                r_hold <= 32'h0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_f3    <= funct3;
                        r_off   <= w_off;
                        r_split <= w_split;
                        r_st    <= store && w_legal;
                        r_ld    <= load && w_legal;
                        r_be_hi <= w_be[7:4];
                        r_wd_hi <= w_wd[63:32];
                        r_wa_nx <= w_wa + WAW'(1);
                        if (w_split) begin
                            r_state <= ST_SPLIT;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= !w_legal;
                            r_rsp_ld    <= load && w_legal;
                        end
                    end
                end
                ST_SPLIT: begin
                    r_lo        <= w_rdata;
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_split <= 1'b1;
                    r_rsp_ld    <= r_ld;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Little-endian assembly across beats, then size/sign extension.
    always_comb begin
        w_raw    = r_split ? {w_rdata, r_lo} : {32'h0, w_rdata};
        w_sh     = 32'(w_raw >> {r_off, 3'b000});
        w_ld_val = 32'h0;
        case (r_f3)
            F3_B:    w_ld_val = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    w_ld_val = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_W:    w_ld_val = w_sh;
            F3_BU:   w_ld_val = {24'h0, w_sh[7:0]};
            F3_HU:   w_ld_val = {16'h0, w_sh[15:0]};
            default: w_ld_val = 32'h0;
        endcase
    end

    assign resp_valid = r_rsp_valid;
    assign resp_split = r_rsp_split;
    assign resp_err   = r_rsp_err;
    assign data_out   = r_rsp_err ? 32'h0
                      : (r_rsp_ld ? w_ld_val : r_hold);

endmodule

// File: tb/tb_lsu_ram.sv
// Directed bench for lsu_ram.
// Hand-computed vectors for sizes, splits, wrap, errors and reset.
module tb_lsu_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        store;
    logic        load;
    logic [2:0]  funct3;
    logic [11:0] address;
    logic [31:0] data_in;
    logic        resp_valid;
    logic        resp_split;
    logic        resp_err;
    logic [31:0] data_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] dq    = 32'h0;

    always #5 clk = ~clk;

    lsu_ram #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .store      (store),
        .load       (load),
        .funct3     (funct3),
        .address    (address),
        .data_in    (data_in),
        .resp_valid (resp_valid),
        .resp_split (resp_split),
        .resp_err   (resp_err),
        .data_out   (data_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One request; xd is the load result (ignored for pure stores,
    // which must leave data_out holding its previous value).
    task automatic xfer(input string tag, input logic st, input logic ld,
                        input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] d, input logic xs,
                        input logic xe, input logic [31:0] xd);
        logic [31:0] exp;
        exp = (ld || xe) ? xd : dq;
        @(negedge clk);
        check({tag, ".rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        store     = st;
        load      = ld;
        funct3    = f3;
        address   = a;
        data_in   = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        store     = 1'b0;
        load      = 1'b0;
        funct3    = 3'b000;
        address   = 12'h000;
        data_in   = 32'h0;
        if (xs) begin
            @(negedge clk);
            check({tag, ".midv"}, 32'(resp_valid), 32'd0);
            check({tag, ".midr"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        check({tag, ".vld"}, 32'(resp_valid), 32'd1);
        check({tag, ".spl"}, 32'(resp_split), 32'(xs));
        check({tag, ".err"}, 32'(resp_err), 32'(xe));
        check({tag, ".dout"}, data_out, exp);
        dq = exp;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        store     = 1'b0;
        load      = 1'b0;
        funct3    = 3'b000;
        address   = 12'h000;
        data_in   = 32'h0;

        repeat (2) @(negedge clk);
        check("rst.rdy", 32'(req_ready), 32'd0);
        check("rst.vld", 32'(resp_valid), 32'd0);
        check("rst.spl", 32'(resp_split), 32'd0);
        check("rst.err", 32'(resp_err), 32'd0);
        check("rst.dout", data_out, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.rdy", 32'(req_ready), 32'd1);

        xfer("pre4", 1, 0, 3'b010, 12'h004, 32'h0, 0, 0, 0);
        xfer("pre8", 1, 0, 3'b010, 12'h008, 32'h0, 0, 0, 0);
        xfer("sw10", 1, 0, 3'b010, 12'h010, 32'hDEADBEEF, 0, 0, 0);
        xfer("lb",   0, 1, 3'b000, 12'h013, 0, 0, 0, 32'hFFFFFFDE);
        xfer("lbu",  0, 1, 3'b100, 12'h013, 0, 0, 0, 32'h000000DE);
        xfer("lh",   0, 1, 3'b001, 12'h012, 0, 0, 0, 32'hFFFFDEAD);
        xfer("lhu",  0, 1, 3'b101, 12'h012, 0, 0, 0, 32'h0000DEAD);
        xfer("lw10", 0, 1, 3'b010, 12'h010, 0, 0, 0, 32'hDEADBEEF);

        xfer("sw6",  1, 0, 3'b010, 12'h006, 32'h11223344, 1, 0, 0);
        xfer("lw4",  0, 1, 3'b010, 12'h004, 0, 0, 0, 32'h33440000);
        xfer("lw8",  0, 1, 3'b010, 12'h008, 0, 0, 0, 32'h00001122);
        xfer("lhu7", 0, 1, 3'b101, 12'h007, 0, 1, 0, 32'h00002233);
        xfer("lh5",  0, 1, 3'b001, 12'h005, 0, 0, 0, 32'h00004400);

        xfer("shw",  1, 0, 3'b001, 12'hFFF, 32'h0000ABCD, 1, 0, 0);
        xfer("bfff", 0, 1, 3'b100, 12'hFFF, 0, 0, 0, 32'h000000CD);
        xfer("b000", 0, 1, 3'b100, 12'h000, 0, 0, 0, 32'h000000AB);
        xfer("lhuw", 0, 1, 3'b101, 12'hFFF, 0, 1, 0, 32'h0000ABCD);
        xfer("lhw",  0, 1, 3'b001, 12'hFFF, 0, 1, 0, 32'hFFFFABCD);

        xfer("sw78", 1, 0, 3'b010, 12'h078, 32'h12345678, 0, 0, 0);
        xfer("sw7c", 1, 0, 3'b010, 12'h07C, 32'hA5A5A5A5, 0, 0, 0);
        xfer("rmw",  1, 1, 3'b010, 12'h07B, 32'hFFFFFFFF, 1, 0,
             32'hA5A5A512);
        xfer("lw78", 0, 1, 3'b010, 12'h078, 0, 0, 0, 32'hFF345678);
        xfer("lw7c", 0, 1, 3'b010, 12'h07C, 0, 0, 0, 32'hA5FFFFFF);

        xfer("e011", 0, 1, 3'b011, 12'h010, 0, 0, 1, 32'h0);
        xfer("lwe1", 0, 1, 3'b010, 12'h010, 0, 0, 0, 32'hDEADBEEF);
        xfer("sbu",  1, 0, 3'b100, 12'h010, 32'h0, 0, 1, 32'h0);
        xfer("lwe2", 0, 1, 3'b010, 12'h010, 0, 0, 0, 32'hDEADBEEF);
        xfer("e111", 0, 1, 3'b111, 12'h013, 0, 0, 1, 32'h0);
        xfer("e110", 1, 1, 3'b110, 12'h011, 32'h0, 0, 1, 32'h0);
        xfer("rmwb", 1, 1, 3'b100, 12'h013, 32'h00000077, 0, 0,
             32'h000000DE);
        xfer("lwe3", 0, 1, 3'b010, 12'h010, 0, 0, 0, 32'h77ADBEEF);

        @(negedge clk);
        req_valid = 1'b1;
        address   = 12'h010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("nop.vld", 32'(resp_valid), 32'd0);
        end
        check("nop.dout", data_out, dq);

        @(negedge clk);
        req_valid = 1'b1;
        store     = 1'b1;
        funct3    = 3'b000;
        address   = 12'h021;
        data_in   = 32'h0000005A;
        @(posedge clk);
        #1;
        store     = 1'b0;
        load      = 1'b1;
        funct3    = 3'b100;
        data_in   = 32'h0;
        @(negedge clk);
        check("b2b.v0", 32'(resp_valid), 32'd1);
        check("b2b.rdy", 32'(req_ready), 32'd1);
        check("b2b.d0", data_out, dq);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load      = 1'b0;
        @(negedge clk);
        check("b2b.v1", 32'(resp_valid), 32'd1);
        check("b2b.d1", data_out, 32'h0000005A);
        dq = 32'h0000005A;

        xfer("pre34", 1, 0, 3'b010, 12'h034, 32'h0, 0, 0, 0);
        xfer("pre38", 1, 0, 3'b010, 12'h038, 32'h0, 0, 0, 0);
        xfer("lwe4",  0, 1, 3'b010, 12'h010, 0, 0, 0, 32'h77ADBEEF);
        @(negedge clk);
        req_valid = 1'b1;
        store     = 1'b1;
        funct3    = 3'b010;
        address   = 12'h036;
        data_in   = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        store     = 1'b0;
        @(negedge clk);
        check("mrs.split", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrs.rdy", 32'(req_ready), 32'd0);
        check("mrs.vld", 32'(resp_valid), 32'd0);
        check("mrs.dout", data_out, 32'h0);
        @(negedge clk);
        check("mrs.nrsp", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        dq    = 32'h0;
        @(negedge clk);
        check("mrs.rel", 32'(req_ready), 32'd1);
        xfer("lw34", 0, 1, 3'b010, 12'h034, 0, 0, 0, 32'h33440000);
        xfer("lw38", 0, 1, 3'b010, 12'h038, 0, 0, 0, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
